// File: rtl/ecp5pll_phase_stepper_if.sv
// Request channel into the ecp5pll phase stepper.
//   req_valid  requester has a request
//   req_ready  stepper can accept (IDLE, out of reset)
//   req_sel    PLL output index 0..3
//   req_dir    phase direction, forwarded to phasedir
//   req_steps  number of phase steps, 0 allowed
interface ecp5pll_phase_stepper_if #(
    parameter int CNT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_sel;
    logic             req_dir;
    logic [CNT_W-1:0] req_steps;

    modport master (output req_valid, req_sel, req_dir, req_steps, input req_ready);
    modport slave  (input req_valid, req_sel, req_dir, req_steps, output req_ready);
endinterface

// File: rtl/ecp5pll_phase_stepper.sv
// ecp5pll_phase_stepper
// Sequences the ecp5pll dynamic phase-shift pins. A request "shift output K by
// N steps in direction D" is accepted in IDLE; each step is a PULSE_CYC-wide
// phasestep pulse followed by GAP_CYC low cycles. Pulses only start after
// SETUP_CYC consecutive locked cycles with phasesel/phasedir stable.
// Ports:
//   clk_i, resetn      clock, synchronous active-low reset
//   req                request channel (slave modport)
//   locked             PLL lock
//   phasesel/phasedir  held from acceptance until the next request
//   phasestep          step pulse
//   phaseloadreg       tied 0
//   busy, done         busy outside IDLE; done pulses one cycle at completion
//   pos_o              per-output phase position, output k at [k*TRACK_W +: TRACK_W]
// Build option: define ECP5PLL_PHASE_TRACK_EN to enable per-output position
// tracking; otherwise pos_o is tied to 0.
module ecp5pll_phase_stepper #(
    parameter int SETUP_CYC = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 8,
    parameter int TRACK_W   = 10
) (
    input  logic                   clk_i,
    input  logic                   resetn,
    ecp5pll_phase_stepper_if.slave req,
    input  logic                   locked,
    output logic [1:0]             phasesel,
    output logic                   phasedir,
    output logic                   phasestep,
    output logic                   phaseloadreg,
    output logic                   busy,
    output logic                   done,
    output logic [4*TRACK_W-1:0]   pos_o
);
    localparam int TMR_MAX0 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int TMR_MAX  = (TMR_MAX0 > GAP_CYC) ? TMR_MAX0 : GAP_CYC;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] remaining, rem_nxt;
    logic             accept;

    assign req.req_ready = (state == IDLE) && resetn;
    assign phaseloadreg  = 1'b0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = remaining;
        accept    = 1'b0;
        case (state)
            IDLE: if (req.req_valid && req.req_ready) begin
                accept    = 1'b1;
                rem_nxt   = req.req_steps;
                cnt_nxt   = '0;
                state_nxt = (req.req_steps == '0) ? DONE : SETUP;
            end
            SETUP: begin
                // any unlocked cycle restarts the stability window
                if (!locked)                                cnt_nxt = '0;
                else if (cnt == TMR_W'(SETUP_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = PULSE;
                end else                                    cnt_nxt = cnt + 1'b1;
            end
            PULSE: begin
                // lock is deliberately ignored so a pulse is never cut short
                if (cnt == TMR_W'(PULSE_CYC - 1)) begin
                    cnt_nxt   = '0;
                    rem_nxt   = remaining - 1'b1;
                    state_nxt = GAP;
                end else cnt_nxt = cnt + 1'b1;
            end
            GAP: begin
                if (cnt == TMR_W'(GAP_CYC - 1)) begin
                    cnt_nxt = '0;
                    if (remaining == '0) state_nxt = DONE;
                    else if (locked)     state_nxt = PULSE;
                    else                 state_nxt = SETUP;
                end else cnt_nxt = cnt + 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
            phasesel  <= '0;
            phasedir  <= 1'b0;
            phasestep <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            remaining <= rem_nxt;
            // outputs registered from the next state so they align with it
            phasestep <= (state_nxt == PULSE);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            if (accept) begin
                phasesel <= req.req_sel;
                phasedir <= req.req_dir;
            end
        end
    end

`ifdef ECP5PLL_PHASE_TRACK_EN
    logic                    step_done;
    logic [3:0][TRACK_W-1:0] pos;

    assign step_done = (state == PULSE) && (cnt == TMR_W'(PULSE_CYC - 1));

    for (genvar k = 0; k < 4; k++) begin : g_track
        always_ff @(posedge clk_i) begin
            if (!resetn)
                pos[k] <= '0;
            else if (step_done && (phasesel == 2'(k)))
                pos[k] <= phasedir ? pos[k] - 1'b1 : pos[k] + 1'b1;
        end
    end
    assign pos_o = pos;
`else
    assign pos_o = '0;
`endif
endmodule
